// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch/issue stage in front of the branch unit. Owns the program
// counter, reads 32-bit words from a synchronous instruction memory, splits the
// held instruction into opcode / register / immediate fields and offers it over
// a valid/ready handshake. Conditional branches stall fetch until the branch
// unit returns the resolved next PC; there is no prediction.
//
// Sequence per instruction: FETCH (strobe memory) -> LATCH (capture read data)
// -> ISSUE (hold until accepted) -> FETCH / BR_WAIT / HALT.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   imem_en         instruction memory read strobe
//   imem_addr       read address (current PC)
//   imem_rdata      read data, valid the cycle after imem_en
//   instr_valid     decoded fields are valid
//   instr_ready     downstream accepts the instruction
//   opcode          ir[31:26]
//   rd_addr         ir[25:21]
//   rs_addr         ir[20:16]
//   imm             ir[15:0], raw (consumer sign-extends)
//   pc_out          PC+1 of the held instruction (branch unit's pc input)
//   br_valid        br_next_pc is resolved
//   br_next_pc      branch target or fall-through
//   halted          HALT instruction accepted
//   issued_count    accepted-instruction counter, saturating
//                   (present only when FETCH_STATS_EN is defined)
//
// Build option
//   FETCH_STATS_EN  adds the issued_count output and its counter.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned            ADDRESS_WIDTH = 5,
  parameter logic [ADDRESS_WIDTH:0] RESET_PC      = '0,
  parameter logic [5:0]             HALT_OPCODE   = 6'b111111
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_en,
  output logic [ADDRESS_WIDTH:0]   imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [5:0]               opcode,
  output logic [4:0]               rd_addr,
  output logic [4:0]               rs_addr,
  output logic [15:0]              imm,
  output logic [ADDRESS_WIDTH:0]   pc_out,
  input  logic                     br_valid,
  input  logic [ADDRESS_WIDTH:0]   br_next_pc,
  output logic                     halted
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]              issued_count
`endif
);

  localparam int unsigned PcW = ADDRESS_WIDTH + 1;

  localparam logic [5:0] BranchLo = 6'b001000;
  localparam logic [5:0] BranchHi = 6'b001101;

  typedef enum logic [2:0] {
    StFetch,
    StLatch,
    StIssue,
    StBrWait,
    StHalt
  } state_e;

  state_e           state_q, state_d;
  logic [PcW-1:0]   pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;

  logic [PcW-1:0]   pc_inc;
  logic             is_branch;
  logic             is_halt;
  logic             accept;

  // Wraps modulo 2^PcW by construction.
  assign pc_inc    = pc_q + PcW'(1);
  assign is_branch = (ir_q[31:26] >= BranchLo) && (ir_q[31:26] <= BranchHi);
  assign is_halt   = (ir_q[31:26] == HALT_OPCODE);
  assign accept    = (state_q == StIssue) && instr_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      StFetch: begin
        state_d = StLatch;
      end
      StLatch: begin
        ir_d    = imem_rdata;
        state_d = StIssue;
      end
      StIssue: begin
        if (instr_ready) begin
          if (is_branch) begin
            // PC is held; the branch unit supplies the next one.
            state_d = StBrWait;
          end else if (is_halt) begin
            state_d = StHalt;
          end else begin
            pc_d    = pc_inc;
            state_d = StFetch;
          end
        end
      end
      StBrWait: begin
        if (br_valid) begin
          pc_d    = br_next_pc;
          state_d = StFetch;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (registered state only; no path from instr_ready or br_valid)
  // ---------------------------------------------------------------------------
  always_comb begin
    // The async reset already forces StFetch; gating with rst keeps the strobe
    // low for the whole time reset is held.
    imem_en     = (state_q == StFetch) && !rst;
    imem_addr   = pc_q;
    instr_valid = (state_q == StIssue);
    halted      = (state_q == StHalt);
    pc_out      = pc_inc;
    opcode      = ir_q[31:26];
    rd_addr     = ir_q[25:21];
    rs_addr     = ir_q[20:16];
    imm         = ir_q[15:0];
  end

`ifdef FETCH_STATS_EN
  // ---------------------------------------------------------------------------
  // Accepted-instruction counter, saturating
  // ---------------------------------------------------------------------------
  logic [15:0] issued_q, issued_d;

  always_comb begin
    issued_d = issued_q;
    if (accept && (issued_q != 16'hFFFF)) begin
      issued_d = issued_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q <= '0;
    end else begin
      issued_q <= issued_d;
    end
  end

  assign issued_count = issued_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
